cuthrough_route_ctrl: RTL and testbench

// - Per-input-port route controller of the cut-through router. Captures the routing header beat,

---
 rtl/noc_route_pkg.sv | 14 +
 rtl/axis_if.sv | 18 +
 rtl/cuthrough_route_selector.sv | 41 ++++
 rtl/cuthrough_route_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cuthrough_route_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_route_pkg.sv
// Shared types and channel indices for the cut-through NoC route controller.
package noc_route_pkg;

    localparam int unsigned CH_LOCAL = 0;
    localparam int unsigned CH_NORTH = 1;
    localparam int unsigned CH_EAST  = 2;
    localparam int unsigned CH_SOUTH = 3;
    localparam int unsigned CH_WEST  = 4;

    typedef enum logic [1:0] {IDLE, ROUTE, FORWARD, DROP} state_t;

    typedef enum logic {ROUTE_XY, ROUTE_YX} route_mode_t;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle with master/slave modports.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DEST_WIDTH = 4,
    parameter int unsigned USER_WIDTH = 4
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport m (output tvalid, tdata, tid, tdest, tuser, tlast, input tready);
    modport s (input tvalid, tdata, tid, tdest, tuser, tlast, output tready);
endinterface

// File: rtl/cuthrough_route_selector.sv
// Dimension-ordered (XY or YX) one-hot output channel selection for a target coordinate.
module cuthrough_route_selector
    import noc_route_pkg::*;
#(
    parameter int unsigned X_W            = 2,
    parameter int unsigned Y_W            = 2,
    parameter int unsigned CHANNEL_NUMBER = 5,
    parameter int unsigned ROUTER_X       = 0,
    parameter int unsigned ROUTER_Y       = 0
) (
    input  logic [X_W-1:0]            i_target_x,
    input  logic [Y_W-1:0]            i_target_y,
    input  route_mode_t               i_mode,
    output logic [CHANNEL_NUMBER-1:0] o_selector
);
    localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
    localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

    logic        w_x_move;
    logic        w_y_move;
    int unsigned w_x_ch;
    int unsigned w_y_ch;
    int unsigned w_ch;

    always_comb begin
        w_x_move = (i_target_x != RX);
        w_y_move = (i_target_y != RY);
        w_x_ch   = (i_target_x > RX) ? CH_EAST : CH_WEST;
        w_y_ch   = (i_target_y > RY) ? CH_SOUTH : CH_NORTH;
        w_ch     = CH_LOCAL;
        if (i_mode == ROUTE_XY) begin
            if (w_x_move)      w_ch = w_x_ch;
            else if (w_y_move) w_ch = w_y_ch;
        end else begin
            if (w_y_move)      w_ch = w_y_ch;
            else if (w_x_move) w_ch = w_x_ch;
        end
        o_selector = CHANNEL_NUMBER'(1) << w_ch;
    end

endmodule

// File: rtl/cuthrough_route_ctrl.sv
// Per-input-port route controller: captures the header, requests an output channel and
// cut-through forwards the packet once granted, policing header range and packet length.
module cuthrough_route_ctrl
    import noc_route_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ID_WIDTH         = 4,
    parameter int unsigned DEST_WIDTH       = 4,
    parameter int unsigned USER_WIDTH       = 4,
    parameter int unsigned CHANNEL_NUMBER   = 5,
    parameter int unsigned MAX_ROUTERS_X    = 4,
    parameter int unsigned MAX_ROUTERS_Y    = 4,
    parameter int unsigned ROUTER_X         = 0,
    parameter int unsigned ROUTER_Y         = 0,
    parameter int unsigned ROUTING_HEADER   = 0,
    parameter int unsigned ROUTE_MODE       = 0,
    parameter int unsigned MAX_PACKET_BEATS = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axis_if.s                         in,
    axis_if.m                         out,
    output logic [CHANNEL_NUMBER-1:0] selector,
    input  logic                      grant,
    output logic                      pkt_active,
    output logic                      err_badhdr,
    output logic                      err_overlong
);
    localparam int unsigned X_W   = $clog2(MAX_ROUTERS_X);
    localparam int unsigned Y_W   = $clog2(MAX_ROUTERS_Y);
    localparam int unsigned CNT_W = $clog2(MAX_PACKET_BEATS + 1);

    localparam logic [ID_WIDTH-1:0] HDR_ID   = ID_WIDTH'(ROUTING_HEADER);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAX_PACKET_BEATS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_PACKET_BEATS);
    localparam route_mode_t         MODE     = (ROUTE_MODE == 0) ? ROUTE_XY : ROUTE_YX;

    state_t                  r_state;
    state_t                  w_state_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_d;
    logic [DATA_WIDTH-1:0]   r_hdr_data;
    logic [ID_WIDTH-1:0]     r_hdr_id;
    logic [DEST_WIDTH-1:0]   r_hdr_dest;
    logic [USER_WIDTH-1:0]   r_hdr_user;
    logic                    r_hdr_last;
    logic                    r_err_badhdr;
    logic                    r_err_overlong;
    logic                    w_err_badhdr_d;
    logic                    w_err_overlong_d;
    logic                    w_hdr_load;
    logic                    w_in_range;
    logic                    w_is_hdr;
    logic                    w_in_hs;
    logic                    w_out_hs;
    logic [CHANNEL_NUMBER-1:0] w_route_sel;

    assign w_is_hdr   = (in.tid == HDR_ID);
    assign w_in_range = (32'(in.tdata[X_W-1:0]) < MAX_ROUTERS_X) &&
                        (32'(in.tdata[X_W+Y_W-1:X_W]) < MAX_ROUTERS_Y);
    assign w_in_hs    = in.tvalid & in.tready;
    assign w_out_hs   = out.tvalid & out.tready;

    cuthrough_route_selector #(
        .X_W            (X_W),
        .Y_W            (Y_W),
        .CHANNEL_NUMBER (CHANNEL_NUMBER),
        .ROUTER_X       (ROUTER_X),
        .ROUTER_Y       (ROUTER_Y)
    ) u_selector (
        .i_target_x (r_hdr_data[X_W-1:0]),
        .i_target_y (r_hdr_data[X_W+Y_W-1:X_W]),
        .i_mode     (MODE),
        .o_selector (w_route_sel)
    );

    // The selector is derived from the stored header, so it holds for the whole packet.
    assign pkt_active   = (r_state == ROUTE) || (r_state == FORWARD);
    assign selector     = pkt_active ? w_route_sel : '0;
    assign err_badhdr   = r_err_badhdr;
    assign err_overlong = r_err_overlong;

    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = r_cnt;
        w_hdr_load       = 1'b0;
        w_err_badhdr_d   = 1'b0;
        w_err_overlong_d = 1'b0;
        in.tready        = 1'b0;
        out.tvalid       = 1'b0;
        out.tdata        = '0;
        out.tid          = '0;
        out.tdest        = '0;
        out.tuser        = '0;
        out.tlast        = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                IDLE: begin
                    in.tready = 1'b1;
                    if (in.tvalid) begin
                        if (w_is_hdr && w_in_range) begin
                            w_hdr_load = 1'b1;
                            w_state_d  = ROUTE;
                        end else begin
                            w_err_badhdr_d = 1'b1;
                            if (w_is_hdr && !in.tlast) w_state_d = DROP;
                        end
                    end
                end
                ROUTE: begin
                    out.tvalid = grant;
                    out.tdata  = r_hdr_data;
                    out.tid    = r_hdr_id;
                    out.tdest  = r_hdr_dest;
                    out.tuser  = r_hdr_user;
                    out.tlast  = r_hdr_last;
                    if (w_out_hs) begin
                        w_cnt_d   = CNT_W'(1);
                        w_state_d = r_hdr_last ? IDLE : FORWARD;
                    end
                end
                FORWARD: begin
                    out.tvalid = in.tvalid & grant;
                    in.tready  = out.tready & grant;
                    out.tdata  = in.tdata;
                    out.tid    = in.tid;
                    out.tdest  = in.tdest;
                    out.tuser  = in.tuser;
                    // The beat that reaches the length limit is always the last one sent.
                    out.tlast  = in.tlast | (r_cnt == CNT_LAST);
                    if (w_in_hs) begin
                        if (r_cnt != CNT_MAX) w_cnt_d = r_cnt + CNT_W'(1);
                        if (in.tlast) begin
                            w_state_d = IDLE;
                        end else if (r_cnt == CNT_LAST) begin
                            w_err_overlong_d = 1'b1;
                            w_state_d        = DROP;
                        end
                    end
                end
                DROP: begin
                    in.tready = 1'b1;
                    if (w_in_hs && in.tlast) w_state_d = IDLE;
                end
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_hdr_data     <= '0;
            r_hdr_id       <= '0;
            r_hdr_dest     <= '0;
            r_hdr_user     <= '0;
            r_hdr_last     <= 1'b0;
            r_err_badhdr   <= 1'b0;
            r_err_overlong <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_err_badhdr   <= w_err_badhdr_d;
            r_err_overlong <= w_err_overlong_d;
            if (w_hdr_load) begin
                r_hdr_data <= in.tdata;
                r_hdr_id   <= in.tid;
                r_hdr_dest <= in.tdest;
                r_hdr_user <= in.tuser;
                r_hdr_last <= in.tlast;
            end
        end
    end

endmodule

// File: tb/tb_cuthrough_route_ctrl.sv
// Directed bench for cuthrough_route_ctrl: router (1,1) on a 4x3 mesh, packets capped at 4 beats.
module tb_cuthrough_route_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned UW = 4;
    localparam int unsigned CN = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic grant = 1'b0;
    logic grant_yx = 1'b0;
    logic [CN-1:0] sel;
    logic [CN-1:0] sel_yx;
    logic pkt_active, pkt_active_yx;
    logic err_badhdr, err_badhdr_yx;
    logic err_overlong, err_overlong_yx;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int hs_base = 0;

    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW)) u_in ();
    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW)) u_out ();
    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW)) u_in_yx ();
    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW)) u_out_yx ();

    cuthrough_route_ctrl #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW), .CHANNEL_NUMBER(CN),
        .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(3), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_HEADER(0), .ROUTE_MODE(0), .MAX_PACKET_BEATS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(u_in), .out(u_out), .selector(sel), .grant(grant),
        .pkt_active(pkt_active), .err_badhdr(err_badhdr), .err_overlong(err_overlong)
    );

    cuthrough_route_ctrl #(
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(SW), .USER_WIDTH(UW), .CHANNEL_NUMBER(CN),
        .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(3), .ROUTER_X(1), .ROUTER_Y(1),
        .ROUTING_HEADER(0), .ROUTE_MODE(1), .MAX_PACKET_BEATS(4)
    ) dut_yx (
        .clk(clk), .rst_n(rst_n), .in(u_in_yx), .out(u_out_yx), .selector(sel_yx),
        .grant(grant_yx), .pkt_active(pkt_active_yx), .err_badhdr(err_badhdr_yx),
        .err_overlong(err_overlong_yx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && u_out.tvalid && u_out.tready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] id,
                         input logic l);
        u_in.tvalid = v;
        u_in.tdata  = d;
        u_in.tid    = id;
        u_in.tdest  = 4'h3;
        u_in.tuser  = d[3:0];
        u_in.tlast  = l;
    endtask

    task automatic drive_yx(input logic v, input logic [31:0] d, input logic l);
        u_in_yx.tvalid = v;
        u_in_yx.tdata  = d;
        u_in_yx.tid    = 4'h0;
        u_in_yx.tdest  = 4'h0;
        u_in_yx.tuser  = 4'h0;
        u_in_yx.tlast  = l;
    endtask

    initial begin
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        drive_yx(1'b0, 32'h0, 1'b0);
        u_out.tready    = 1'b1;
        u_out_yx.tready = 1'b1;

        // Reset state
        step();
        settle();
        chk("rst_in_tready", u_in.tready, 0);
        step();
        settle();
        chk("rst_selector", sel, 0);
        chk("rst_pkt_active", pkt_active, 0);
        chk("rst_out_tvalid", u_out.tvalid, 0);
        chk("rst_err", {err_badhdr, err_overlong}, 0);
        rst_n = 1'b1;
        step();
        settle();
        chk("idle_in_tready", u_in.tready, 1);

        // XY: header x=3,y=2 -> east, 4-beat packet
        grant = 1'b1;
        hs_base = hs_cnt;
        drive(1'b1, 32'h0000_000B, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h0000_1111, 4'h1, 1'b0);
        settle();
        chk("route_selector_east", sel, 5'b00100);
        chk("route_pkt_active", pkt_active, 1);
        chk("route_in_tready", u_in.tready, 0);
        chk("route_out_tvalid", u_out.tvalid, 1);
        chk("route_out_tdata", u_out.tdata, 32'h0000_000B);
        chk("route_out_tid", u_out.tid, 0);
        step();
        settle();
        chk("fwd_b2_tdata", u_out.tdata, 32'h0000_1111);
        chk("fwd_b2_in_tready", u_in.tready, 1);
        chk("fwd_b2_tuser", u_out.tuser, 4'h1);
        step();
        drive(1'b1, 32'h0000_2222, 4'h1, 1'b0);
        settle();
        chk("fwd_b3_tdata", u_out.tdata, 32'h0000_2222);
        chk("fwd_b3_selector", sel, 5'b00100);
        step();
        drive(1'b1, 32'h0000_3333, 4'h1, 1'b1);
        settle();
        chk("fwd_b4_tdata", u_out.tdata, 32'h0000_3333);
        chk("fwd_b4_tlast", u_out.tlast, 1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("pkt1_done_selector", sel, 0);
        chk("pkt1_done_pkt_active", pkt_active, 0);
        chk("pkt1_beats_out", hs_cnt - hs_base, 4);

        // Grant stalls: header x=0,y=0 -> west; 3 cycles in ROUTE, 2 cycles mid-FORWARD
        grant = 1'b0;
        hs_base = hs_cnt;
        drive(1'b1, 32'h0000_0000, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h0000_AAAA, 4'h2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_route_out_tvalid", u_out.tvalid, 0);
            chk("stall_route_in_tready", u_in.tready, 0);
            chk("stall_route_selector", sel, 5'b10000);
            step();
        end
        grant = 1'b1;
        settle();
        chk("stall_route_release", {u_out.tvalid, u_out.tdata}, {1'b1, 32'h0});
        step();
        settle();
        chk("stall_b2_tdata", u_out.tdata, 32'h0000_AAAA);
        step();
        drive(1'b1, 32'h0000_BBBB, 4'h2, 1'b0);
        grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("stall_fwd_out_tvalid", u_out.tvalid, 0);
            chk("stall_fwd_in_tready", u_in.tready, 0);
            step();
        end
        grant = 1'b1;
        settle();
        chk("stall_b3_tdata", {u_out.tvalid, u_out.tdata}, {1'b1, 32'h0000_BBBB});
        step();
        drive(1'b1, 32'h0000_CCCC, 4'h2, 1'b1);
        settle();
        chk("stall_b4_tdata", u_out.tdata, 32'h0000_CCCC);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("pkt2_beats_out", hs_cnt - hs_base, 4);
        chk("pkt2_done_pkt_active", pkt_active, 0);

        // Local: single-beat header x=1,y=1
        drive(1'b1, 32'h0000_0005, 4'h0, 1'b1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("local_selector", sel, 5'b00001);
        chk("local_out_tlast", u_out.tlast, 1);
        step();
        settle();
        chk("local_done_pkt_active", pkt_active, 0);

        // Data beat in IDLE
        drive(1'b1, 32'h0000_0777, 4'h1, 1'b0);
        settle();
        chk("bad_in_tready", u_in.tready, 1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("bad_err_pulse", err_badhdr, 1);
        chk("bad_stay_idle", pkt_active, 0);
        step();
        settle();
        chk("bad_err_once", err_badhdr, 0);

        // Out-of-range header y=3 without TLAST -> DROP until TLAST
        drive(1'b1, 32'h0000_000C, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h0000_0999, 4'h1, 1'b1);
        settle();
        chk("range_err_pulse", err_badhdr, 1);
        chk("range_drop_out_tvalid", u_out.tvalid, 0);
        chk("range_drop_selector", sel, 0);
        chk("range_drop_in_tready", u_in.tready, 1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("range_drop_no_err", err_badhdr, 0);

        // Overlong: 7-beat packet with a 4-beat limit
        hs_base = hs_cnt;
        drive(1'b1, 32'h0000_000B, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h0000_0102, 4'h1, 1'b0);
        step();
        step();
        drive(1'b1, 32'h0000_0103, 4'h1, 1'b0);
        step();
        drive(1'b1, 32'h0000_0104, 4'h1, 1'b0);
        settle();
        chk("long_b4_tdata", u_out.tdata, 32'h0000_0104);
        chk("long_b4_forced_tlast", u_out.tlast, 1);
        step();
        drive(1'b1, 32'h0000_0105, 4'h1, 1'b0);
        settle();
        chk("long_err_pulse", err_overlong, 1);
        chk("long_drop_out_tvalid", u_out.tvalid, 0);
        chk("long_drop_selector", sel, 0);
        step();
        drive(1'b1, 32'h0000_0106, 4'h1, 1'b0);
        settle();
        chk("long_err_once", err_overlong, 0);
        step();
        drive(1'b1, 32'h0000_0107, 4'h1, 1'b1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("long_beats_out", hs_cnt - hs_base, 4);
        chk("long_idle_in_tready", u_in.tready, 1);
        chk("long_idle_pkt_active", pkt_active, 0);

        // Reset mid-FORWARD
        drive(1'b1, 32'h0000_000B, 4'h0, 1'b0);
        step();
        drive(1'b1, 32'h0000_0201, 4'h1, 1'b0);
        step();
        rst_n = 1'b0;
        settle();
        chk("midrst_in_tready", u_in.tready, 0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("midrst_selector", sel, 0);
        chk("midrst_out_tvalid", u_out.tvalid, 0);
        chk("midrst_pkt_active", pkt_active, 0);
        drive(1'b1, 32'h0000_0005, 4'h0, 1'b1);
        step();
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        settle();
        chk("midrst_next_selector", sel, 5'b00001);
        step();

        // YX mode: x=3,y=2 -> south; x=0,y=0 -> north
        grant_yx = 1'b1;
        drive_yx(1'b1, 32'h0000_000B, 1'b1);
        step();
        drive_yx(1'b0, 32'h0, 1'b0);
        settle();
        chk("yx_selector_south", sel_yx, 5'b01000);
        chk("yx_out_tdata", u_out_yx.tdata, 32'h0000_000B);
        step();
        drive_yx(1'b1, 32'h0000_0000, 1'b1);
        step();
        drive_yx(1'b0, 32'h0, 1'b0);
        settle();
        chk("yx_selector_north", sel_yx, 5'b00010);
        step();
        settle();
        chk("yx_idle", {pkt_active_yx, err_badhdr_yx, err_overlong_yx}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
